// File: rtl/mdio_req_arbiter.sv
// ---------------------------------------------------------------------------
// mdio_req_arbiter
// Shares one MDIO master between NUM_REQ requesters (link poller, CPU port,
// PHY init sequencer). Grants round-robin, strobes req_enb until the master
// reports busy, waits for completion, then returns a response pulse to the
// requester that owns the transaction. A grant-to-completion watchdog aborts
// hung transactions with an error response.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   rq_valid[i]         requester i has a request pending (held until ready)
//   rq_op/phy/reg/wdata per-requester command fields, packed by index
//   rq_ready            one-hot pulse: request accepted
//   rsp_valid           one-hot pulse: transaction finished
//   rsp_err             qualifies rsp_valid: timeout or illegal op
//   rsp_data            read data (0xFFFF on timeout)
//   req_enb/req_op/phy_addr/reg_addr/wr_data   command to the MDIO master
//   work_bit, data_sta, sta_enb                status from the MDIO master
// ---------------------------------------------------------------------------
module mdio_req_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      rq_valid,
  input  logic [2*NUM_REQ-1:0]    rq_op,
  input  logic [5*NUM_REQ-1:0]    rq_phy,
  input  logic [5*NUM_REQ-1:0]    rq_reg,
  input  logic [16*NUM_REQ-1:0]   rq_wdata,
  output logic [NUM_REQ-1:0]      rq_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_err,
  output logic [15:0]             rsp_data,
  output logic                    req_enb,
  output logic [1:0]              req_op,
  output logic [4:0]              phy_addr,
  output logic [4:0]              reg_addr,
  output logic [15:0]             wr_data,
  input  logic                    work_bit,
  input  logic [15:0]             data_sta,
  input  logic                    sta_enb
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ILL} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        ptr, ptr_nx;
  logic [IW-1:0]        owner, owner_nx;
  logic [TW-1:0]        timer, timer_nx;
  logic [NUM_REQ-1:0]   rq_ready_nx, rsp_valid_nx;
  logic                 rsp_err_nx, req_enb_nx;
  logic [15:0]          rsp_data_nx, wr_data_nx;
  logic [1:0]           req_op_nx;
  logic [4:0]           phy_addr_nx, reg_addr_nx;

  // round-robin search results
  logic                 found;
  logic [IW-1:0]        win;
  logic [IW:0]          cand;
  logic [1:0]           win_op;
  logic                 timed_out;
  logic                 done;

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign timed_out = (timer == TW'(TIMEOUT_CYC - 1));
  // reads finish on the data strobe, writes when the master drops busy
  assign done      = (req_op == OP_RD) ? sta_enb : !work_bit;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    found        = 1'b0;
    win          = '0;
    cand         = '0;
    state_nx     = state;
    ptr_nx       = ptr;
    owner_nx     = owner;
    timer_nx     = timer;
    rq_ready_nx  = '0;
    rsp_valid_nx = '0;
    rsp_err_nx   = 1'b0;
    rsp_data_nx  = rsp_data;
    req_enb_nx   = req_enb;
    req_op_nx    = req_op;
    phy_addr_nx  = phy_addr;
    reg_addr_nx  = reg_addr;
    wr_data_nx   = wr_data;

    // scan ptr+1 .. ptr+NUM_REQ, wrapping, first set request wins
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (IW+1)'(ptr) + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && rq_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
    win_op = rq_op[2*win +: 2];

    case (state)
      S_IDLE: begin
        if (found && !work_bit) begin
          rq_ready_nx = one_hot(win);
          ptr_nx      = win;
          owner_nx    = win;
          timer_nx    = '0;
          if (win_op == OP_RD || win_op == OP_WR) begin
            req_op_nx   = win_op;
            phy_addr_nx = rq_phy[5*win +: 5];
            reg_addr_nx = rq_reg[5*win +: 5];
            wr_data_nx  = rq_wdata[16*win +: 16];
            state_nx    = S_ISSUE;
          end else begin
            // illegal op never reaches the master
            state_nx = S_ILL;
          end
        end
      end
      S_ILL: begin
        rsp_valid_nx = one_hot(owner);
        rsp_err_nx   = 1'b1;
        state_nx     = S_IDLE;
      end
      S_ISSUE: begin
        timer_nx = timer + 1'b1;
        if (timed_out) begin
          req_enb_nx   = 1'b0;
          rsp_valid_nx = one_hot(owner);
          rsp_err_nx   = 1'b1;
          rsp_data_nx  = 16'hFFFF;
          state_nx     = S_IDLE;
        end else if (work_bit) begin
          req_enb_nx = 1'b0;
          state_nx   = S_WAIT;
        end else begin
          req_enb_nx = 1'b1;
        end
      end
      S_WAIT: begin
        timer_nx = timer + 1'b1;
        // completion is checked first so it wins a tie with the watchdog
        if (done) begin
          rsp_valid_nx = one_hot(owner);
          if (req_op == OP_RD) rsp_data_nx = data_sta;
          state_nx = S_RESP;
        end else if (timed_out) begin
          rsp_valid_nx = one_hot(owner);
          rsp_err_nx   = 1'b1;
          rsp_data_nx  = 16'hFFFF;
          state_nx     = S_IDLE;
        end
      end
      S_RESP: begin
        // rsp_valid is high during this state; one idle cycle before next grant
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      owner     <= '0;
      timer     <= '0;
      rq_ready  <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      req_enb   <= 1'b0;
      req_op    <= OP_RD;
      phy_addr  <= '0;
      reg_addr  <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      timer     <= timer_nx;
      rq_ready  <= rq_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
      rsp_data  <= rsp_data_nx;
      req_enb   <= req_enb_nx;
      req_op    <= req_op_nx;
      phy_addr  <= phy_addr_nx;
      reg_addr  <= reg_addr_nx;
      wr_data   <= wr_data_nx;
    end
  end

endmodule

// File: tb/tb_mdio_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mdio_req_arbiter
// Scoreboard bench: each request pushes its expected grant and response;
// a per-cycle routine pops and compares them as the DUT produces rq_ready and
// rsp_valid, and also plays the MDIO master.
// ---------------------------------------------------------------------------
module tb_mdio_req_arbiter;

  localparam int N  = 3;
  localparam int TO = 64;
  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b01;

  typedef enum int {M_NORMAL, M_NEVER, M_STUCK} mmode_t;
  typedef enum int {K_OK, K_TIMEOUT, K_ILLEGAL} kind_t;

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [4:0] phy;
    logic [4:0] rg;
    logic [15:0] wd;
  } grant_t;

  typedef struct {
    int          idx;
    logic        err;
    logic        chk_data;
    logic [15:0] data;
    int          lat;     // cycles from grant to response, 0 = not checked
  } rsp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   rq_valid;
  logic [2*N-1:0] rq_op;
  logic [5*N-1:0] rq_phy, rq_reg;
  logic [16*N-1:0] rq_wdata;
  logic [N-1:0]   rq_ready, rsp_valid;
  logic           rsp_err;
  logic [15:0]    rsp_data;
  logic           req_enb;
  logic [1:0]     req_op;
  logic [4:0]     phy_addr, reg_addr;
  logic [15:0]    wr_data;
  logic           work_bit;
  logic [15:0]    data_sta;
  logic           sta_enb;

  mdio_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_op(rq_op), .rq_phy(rq_phy), .rq_reg(rq_reg),
    .rq_wdata(rq_wdata), .rq_ready(rq_ready), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .req_enb(req_enb),
    .req_op(req_op), .phy_addr(phy_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .work_bit(work_bit), .data_sta(data_sta),
    .sta_enb(sta_enb)
  );

  always #40 clk = ~clk;   // 12.5 MHz

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     grant_cyc = 0;
  int     done_cyc = 0;
  int     hold_left = 0;
  grant_t grant_q[$];
  rsp_t   rsp_q[$];
  grant_t cur;
  mmode_t m_mode = M_NORMAL;
  int     ms = 0;
  int     md = 0;
  logic   m_first = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] oh(input int i);
    logic [2:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // read data the master model returns for a given address pair
  function automatic logic [15:0] rd_val(input logic [4:0] p, input logic [4:0] r);
    return 16'h796D ^ {p, r ^ 5'd1, 6'd0};
  endfunction

  task automatic drive_req(input int i, input logic [1:0] op, input logic [4:0] p,
                           input logic [4:0] r, input logic [15:0] wd);
    rq_op[2*i +: 2]     = op;
    rq_phy[5*i +: 5]    = p;
    rq_reg[5*i +: 5]    = r;
    rq_wdata[16*i +: 16] = wd;
    rq_valid[i]         = 1'b1;
  endtask

  task automatic expect_txn(input int i, input logic [1:0] op, input logic [4:0] p,
                            input logic [4:0] r, input logic [15:0] wd, input kind_t k);
    grant_t g;
    rsp_t   s;
    g.idx = i; g.op = op; g.phy = p; g.rg = r; g.wd = wd;
    grant_q.push_back(g);
    s.idx = i;
    s.err = (k != K_OK);
    s.chk_data = (k == K_TIMEOUT) || (k == K_OK && op == RD);
    s.data = (k == K_TIMEOUT) ? 16'hFFFF : rd_val(p, r);
    s.lat = (k == K_TIMEOUT) ? TO : (k == K_ILLEGAL) ? 1 : 0;
    rsp_q.push_back(s);
  endtask

  // one clock: sample after the edge, score grants/responses, run master model
  task automatic tick();
    grant_t g;
    rsp_t   s;
    @(posedge clk);
    #1;
    cyc++;
    if (rq_ready != '0) begin
      if (grant_q.size() == 0) check("spurious_ready", 32'(rq_ready), 32'd0);
      else begin
        g = grant_q.pop_front();
        check("grant", 32'(rq_ready), 32'(oh(g.idx)));
        cur = g;
        grant_cyc = cyc;
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) rq_valid = '0;
        end else begin
          rq_valid[g.idx] = 1'b0;
        end
      end
    end
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) check("spurious_rsp", 32'(rsp_valid), 32'd0);
      else begin
        s = rsp_q.pop_front();
        check("rsp_owner", 32'(rsp_valid), 32'(oh(s.idx)));
        check("rsp_err", 32'(rsp_err), 32'(s.err));
        if (s.chk_data) check("rsp_data", 32'(rsp_data), 32'(s.data));
        if (s.lat > 0) check("rsp_lat", cyc - grant_cyc, s.lat);
        else check("done_lat", cyc - done_cyc, 1);
        check("enb_off_at_rsp", 32'(req_enb), 32'd0);
      end
    end
    sta_enb = 1'b0;
    case (ms)
      0: if (req_enb && m_mode != M_NEVER) begin
        check("req_op", 32'(req_op), 32'(cur.op));
        check("phy_addr", 32'(phy_addr), 32'(cur.phy));
        check("reg_addr", 32'(reg_addr), 32'(cur.rg));
        if (cur.op == WR) check("wr_data", 32'(wr_data), 32'(cur.wd));
        ms = 1;
        md = 3;
      end
      1: begin
        check("enb_hold", 32'(req_enb), 32'd1);
        check("phy_stable", 32'(phy_addr), 32'(cur.phy));
        md--;
        if (md == 0) begin
          work_bit = 1'b1;
          ms = 2;
          md = (m_mode == M_STUCK) ? 1000000 : 4;
          m_first = 1'b1;
        end
      end
      default: begin
        if (m_first) check("enb_drop", 32'(req_enb), 32'd0);
        m_first = 1'b0;
        md--;
        if (md == 0) begin
          if (req_op == RD) begin
            sta_enb  = 1'b1;
            data_sta = rd_val(phy_addr, reg_addr);
          end
          work_bit = 1'b0;
          done_cyc = cyc;
          ms = 0;
        end
      end
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (grant_q.size() != 0 || rsp_q.size() != 0 || ms != 0); i++)
      tick();
    check("drain_grants", grant_q.size(), 0);
    check("drain_rsps", rsp_q.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    reset    = 1'b0;
    rq_valid = '0;
    rq_op    = '0;
    rq_phy   = '0;
    rq_reg   = '0;
    rq_wdata = '0;
    work_bit = 1'b0;
    data_sta = '0;
    sta_enb  = 1'b0;
    cur      = '{idx: 0, op: RD, phy: 5'd0, rg: 5'd0, wd: 16'd0};
    repeat (2) tick();
    check("rst_rq_ready", 32'(rq_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_enb", 32'(req_enb), 32'd0);
    check("rst_req_op", 32'(req_op), 32'(RD));
    check("rst_addr", {22'd0, phy_addr, reg_addr}, 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b1;
    tick();

    // fairness: all three held valid, six grants in order 0,1,2,0,1,2
    hold_left = 6;
    for (int i = 0; i < N; i++) drive_req(i, RD, 5'(i + 1), 5'(i + 4), 16'd0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) expect_txn(i, RD, 5'(i + 1), 5'(i + 4), 16'd0, K_OK);
    drain();

    // read from req0 with the two-cycle request-to-strobe latency
    drive_req(0, RD, 5'd0, 5'd1, 16'd0);
    expect_txn(0, RD, 5'd0, 5'd1, 16'd0, K_OK);
    tick();
    check("lat_enb_c1", 32'(req_enb), 32'd0);
    tick();
    check("lat_enb_c2", 32'(req_enb), 32'd1);
    drain();

    // write from req1
    drive_req(1, WR, 5'd2, 5'd0, 16'h1200);
    expect_txn(1, WR, 5'd2, 5'd0, 16'h1200, K_OK);
    drain();

    // watchdog: master never answers
    m_mode = M_NEVER;
    drive_req(2, RD, 5'd5, 5'd6, 16'd0);
    expect_txn(2, RD, 5'd5, 5'd6, 16'd0, K_TIMEOUT);
    drain();
    m_mode = M_NORMAL;

    // illegal op: error response without touching the master
    drive_req(1, 2'b11, 5'd9, 5'd9, 16'hDEAD);
    expect_txn(1, 2'b11, 5'd9, 5'd9, 16'hDEAD, K_ILLEGAL);
    drain();
    check("ill_master_untouched", 32'(phy_addr), 32'd5);

    // busy gate: no grant while work_bit is high; stray sta_enb ignored
    work_bit = 1'b1;
    drive_req(0, RD, 5'd3, 5'd2, 16'd0);
    expect_txn(0, RD, 5'd3, 5'd2, 16'd0, K_OK);
    for (int i = 0; i < 3; i++) begin
      sta_enb = (i == 1);
      tick();
      check("gate_hold", 32'(rq_ready), 32'd0);
    end
    work_bit = 1'b0;
    tick();
    check("gate_grant", 32'(rq_ready), 32'd1);
    drain();

    // asynchronous reset while the master is busy
    m_mode = M_STUCK;
    drive_req(2, WR, 5'd3, 5'd4, 16'hABCD);
    expect_txn(2, WR, 5'd3, 5'd4, 16'hABCD, K_OK);
    for (int i = 0; i < 100 && ms != 2; i++) tick();
    check("reached_wait", ms, 2);
    repeat (3) tick();
    #5 reset = 1'b0;
    #1;
    check("arst_req_enb", 32'(req_enb), 32'd0);
    check("arst_req_op", 32'(req_op), 32'(RD));
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_q.delete();
    grant_q.delete();
    work_bit = 1'b0;
    ms       = 0;
    m_mode   = M_NORMAL;
    rq_valid = '0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    drive_req(2, RD, 5'd7, 5'd9, 16'd0);
    expect_txn(2, RD, 5'd7, 5'd9, 16'd0, K_OK);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
